// File: rtl/ddr_wr_data_capture.sv
// Memory-model write-data receiver: queues write commands, waits each one's write latency,
// checks the DQS preamble and strobe toggling, then assembles BL beats of DQ into one word.
module ddr_wr_data_capture #(
    parameter int DQ_W      = 8,
    parameter int MAX_BL    = 8,
    parameter int ADDR_W    = 24,
    parameter int CMD_DEPTH = 4
) (
    input  logic                   CK_t,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_rdy,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [3:0]             cmd_bl,
    input  logic [1:0]             cmd_pre,
    input  logic [4:0]             cmd_cwl,
    input  logic [DQ_W-1:0]        dq,
    input  logic                   dqs_t,
    input  logic                   dqs_c,
    output logic                   wr_valid,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DQ_W*MAX_BL-1:0] wr_data,
    output logic                   err_pre,
    output logic                   err_dqs,
    output logic                   err_late,
    output logic                   busy
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = DQ_W * MAX_BL;

    typedef enum logic [1:0] {IDLE, WAIT, PRE, BURST} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        bl;
        logic [1:0]        pre;
        logic [15:0]       stamp;
        logic [4:0]        dly;
    } ent_t;

    state_t            state_q, state_d;
    ent_t              fifo_q [CMD_DEPTH];
    ent_t              in_ent;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nx;
    logic [CW-1:0]     count_q, count_d;
    logic [15:0]       cyc_q;
    logic [3:0]        ph_q, ph_d;
    logic              sticky_q, sticky_d;
    logic [DW-1:0]     data_q, data_d, data_nx;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic              err_pre_q, err_pre_d, err_dqs_q, err_dqs_d, err_late_q, err_late_d;
    logic              full, push, rel, beat_bad;
    logic              sel_on, sel_vld, sel_fifo;
    logic [15:0]       sel_stamp;
    logic [4:0]        sel_dly, in_dly;
    logic [1:0]        pop_n;

    function automatic logic is_late(input logic [15:0] now, input logic [15:0] stamp,
                                     input logic [4:0] dly);
        logic [15:0] age;
        age = now - stamp;
        return age > {11'd0, dly};
    endfunction

    function automatic logic due_next(input logic [15:0] now, input logic [15:0] stamp,
                                      input logic [4:0] dly);
        logic [15:0] age;
        age = now + 16'd1 - stamp;
        return age == {11'd0, dly};
    endfunction

    assign full  = (count_q == CW'(CMD_DEPTH));
    assign push  = cmd_valid && !full;
    assign rd_nx = rd_ptr_q + PW'(1);

    always_comb begin
        in_dly = (cmd_cwl > {3'd0, cmd_pre}) ? cmd_cwl - {3'd0, cmd_pre} : 5'd1;
        in_ent = '{addr: cmd_addr, bl: cmd_bl, pre: cmd_pre, stamp: cyc_q, dly: in_dly};
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        sticky_d   = sticky_q;
        data_d     = data_q;
        data_nx    = data_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_pre_d  = 1'b0;
        err_dqs_d  = 1'b0;
        err_late_d = 1'b0;
        rel        = 1'b0;
        pop_n      = 2'd0;
        beat_bad   = 1'b0;
        sel_on     = 1'b0;
        sel_fifo   = 1'b0;
        sel_vld    = 1'b0;
        sel_stamp  = cyc_q;
        sel_dly    = in_dly;

        case (state_q)
            IDLE, WAIT: begin
                // An empty FIFO lets the command being accepted this cycle be the head.
                sel_on   = 1'b1;
                sel_fifo = (count_q != '0);
                sel_vld  = sel_fifo || push;
                if (sel_fifo) begin
                    sel_stamp = fifo_q[rd_ptr_q].stamp;
                    sel_dly   = fifo_q[rd_ptr_q].dly;
                end
            end
            PRE: begin
                if (!dqs_t || dqs_c) begin
                    err_pre_d = 1'b1;
                    rel       = 1'b1;
                end else if (ph_q == {2'b00, fifo_q[rd_ptr_q].pre} - 4'd1) begin
                    state_d = BURST;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            BURST: begin
                beat_bad = (dqs_t == dqs_c) || (dqs_t != ph_q[0]);
                for (int k = 0; k < MAX_BL; k++) begin
                    if (ph_q == 4'(k)) data_nx[k*DQ_W +: DQ_W] = dq;
                end
                data_d   = data_nx;
                sticky_d = sticky_q || beat_bad;
                if (ph_q == fifo_q[rd_ptr_q].bl - 4'd1) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = fifo_q[rd_ptr_q].addr;
                    wr_data_d  = data_nx;
                    err_dqs_d  = sticky_q || beat_bad;
                    rel        = 1'b1;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Releasing the current entry: the one behind it decides seamless PRE, WAIT or IDLE.
        if (rel) begin
            sel_on   = 1'b1;
            pop_n    = 2'd1;
            sel_fifo = (count_q > CW'(1));
            sel_vld  = sel_fifo || push;
            if (sel_fifo) begin
                sel_stamp = fifo_q[rd_nx].stamp;
                sel_dly   = fifo_q[rd_nx].dly;
            end
        end

        if (sel_on) begin
            if (sel_vld && sel_fifo && is_late(cyc_q, sel_stamp, sel_dly)) begin
                pop_n      = pop_n + 2'd1;
                err_late_d = 1'b1;
                state_d    = WAIT;
            end else if (sel_vld && due_next(cyc_q, sel_stamp, sel_dly)) begin
                state_d  = PRE;
                ph_d     = '0;
                data_d   = '0;
                sticky_d = 1'b0;
            end else begin
                state_d = WAIT;
            end
        end

        count_d  = count_q + CW'(push) - CW'(pop_n);
        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        wr_ptr_d = wr_ptr_q + PW'(push);
        if (state_d == WAIT && count_d == '0) state_d = IDLE;
    end

    always_ff @(posedge CK_t) begin
        if (push) fifo_q[wr_ptr_q] <= in_ent;
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ph_q       <= '0;
            sticky_q   <= 1'b0;
            data_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_pre_q  <= 1'b0;
            err_dqs_q  <= 1'b0;
            err_late_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_q + 16'd1;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ph_q       <= ph_d;
            sticky_q   <= sticky_d;
            data_q     <= data_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_pre_q  <= err_pre_d;
            err_dqs_q  <= err_dqs_d;
            err_late_q <= err_late_d;
        end
    end

    assign cmd_rdy  = !full;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err_pre  = err_pre_q;
    assign err_dqs  = err_dqs_q;
    assign err_late = err_late_q;
    assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ddr_wr_data_capture.sv
// Scoreboard bench: directed commands and DQ/DQS bursts; a negedge monitor matches every output pulse.
module tb_ddr_wr_data_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rdy;
    logic [23:0] cmd_addr = '0;
    logic [3:0]  cmd_bl = 4'd8;
    logic [1:0]  cmd_pre = 2'd1;
    logic [4:0]  cmd_cwl = 5'd9;
    logic [7:0]  dq = '0;
    logic        dqs_t = 1'b0;
    logic        dqs_c = 1'b1;
    logic        wr_valid, err_pre, err_dqs, err_late, busy;
    logic [23:0] wr_addr;
    logic [63:0] wr_data;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        int          at;
        logic [23:0] addr;
        logic [63:0] data;
        logic        dqs;
    } exp_t;
    exp_t exp_q[$];

    ddr_wr_data_capture dut (
        .CK_t(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy),
        .cmd_addr(cmd_addr), .cmd_bl(cmd_bl), .cmd_pre(cmd_pre), .cmd_cwl(cmd_cwl),
        .dq(dq), .dqs_t(dqs_t), .dqs_c(dqs_c), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .err_pre(err_pre), .err_dqs(err_dqs), .err_late(err_late),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input logic [23:0] addr,
                             input logic [63:0] data, input logic dqs);
        exp_t e;
        e.kind = kind; e.at = at; e.addr = addr; e.data = data; e.dqs = dqs;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected pulse at cycle %0d, want none", name, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk({name, " kind"}, 64'(kind), 64'(e.kind));
        chk({name, " cycle"}, 64'(cyc), 64'(e.at));
        if (kind == 0) begin
            chk("wr_addr", 64'(wr_addr), 64'(e.addr));
            chk("wr_data", wr_data, e.data);
            chk("err_dqs", 64'(err_dqs), 64'(e.dqs));
        end
    endtask

    always @(negedge clk) begin
        if (wr_valid === 1'b1) observe(0, "wr_valid");
        if (err_pre === 1'b1)  observe(1, "err_pre");
        if (err_late === 1'b1) observe(2, "err_late");
        if (err_dqs === 1'b1 && wr_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL err_dqs: pulse without wr_valid at cycle %0d", cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int n);
        for (int i = 0; i < 2000 && cyc != n; i++) step();
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait: cycle %0d never reached (now %0d)", n, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [23:0] addr, input int bl, input int pre, input int cwl,
                        input logic exp_rdy);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_bl    = 4'(bl);
        cmd_pre   = 2'(pre);
        cmd_cwl   = 5'(cwl);
        chk("cmd_rdy at send", 64'(cmd_rdy), 64'(exp_rdy));
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic burst(input int start, input int pre, input int bl, input logic [63:0] data,
                         input logic bad_pre, input logic stuck);
        at(start);
        for (int p = 0; p < pre; p++) begin
            dqs_t = !bad_pre;
            dqs_c = 1'b0;
            step();
        end
        if (!bad_pre) begin
            for (int k = 0; k < bl; k++) begin
                dq    = data[k*8 +: 8];
                dqs_t = stuck ? 1'b0 : (k % 2 == 1);
                dqs_c = !dqs_t;
                step();
            end
        end
        dq    = '0;
        dqs_t = 1'b0;
        dqs_c = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        do_reset();
        chk("reset cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("reset wr_valid", 64'(wr_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset errs", 64'({err_pre, err_dqs, err_late}), 64'd0);
        chk("reset wr_data", wr_data, 64'd0);
        chk("reset wr_addr", 64'(wr_addr), 64'd0);

        // BL8 pre1 cwl9 accepted at 10, then a BL4 over the old word
        at(10);
        send(24'h123456, 8, 1, 9, 1'b1);
        expect_ev(0, 27, 24'h123456, 64'h8877665544332211, 1'b0);
        burst(18, 1, 8, 64'h8877665544332211, 1'b0, 1'b0);
        at(30);
        chk("hold wr_valid", 64'(wr_valid), 64'd0);
        chk("hold wr_data", wr_data, 64'h8877665544332211);
        at(40);
        send(24'h0000A4, 4, 2, 10, 1'b1);
        expect_ev(0, 54, 24'h0000A4, 64'h00000000A4A3A2A1, 1'b0);
        burst(48, 2, 4, 64'h00000000A4A3A2A1, 1'b0, 1'b0);
        at(58);
        chk("idle busy", 64'(busy), 64'd0);

        // BL4 pre2 cwl10 accepted at 0
        do_reset();
        send(24'hABCDEF, 4, 2, 10, 1'b1);
        expect_ev(0, 14, 24'hABCDEF, 64'h00000000A4A3A2A1, 1'b0);
        burst(8, 2, 4, 64'h00000000A4A3A2A1, 1'b0, 1'b0);
        at(16);

        // Bad preamble, next command still serviced back to back
        do_reset();
        at(10);
        send(24'h000111, 8, 1, 9, 1'b1);
        send(24'h000222, 8, 1, 9, 1'b1);
        expect_ev(1, 19, '0, '0, 1'b0);
        expect_ev(0, 28, 24'h000222, 64'hF8F7F6F5F4F3F2F1, 1'b0);
        burst(18, 1, 8, '0, 1'b1, 1'b0);
        burst(19, 1, 8, 64'hF8F7F6F5F4F3F2F1, 1'b0, 1'b0);
        at(31);

        // Two seamless bursts
        do_reset();
        expect_ev(0, 27, 24'h000100, 64'h8877665544332211, 1'b0);
        expect_ev(0, 36, 24'h000200, 64'h0F1E2D3C4B5A6978, 1'b0);
        fork
            begin
                at(10);
                send(24'h000100, 8, 1, 9, 1'b1);
                at(19);
                send(24'h000200, 8, 1, 9, 1'b1);
            end
            begin
                burst(18, 1, 8, 64'h8877665544332211, 1'b0, 1'b0);
                burst(27, 1, 8, 64'h0F1E2D3C4B5A6978, 1'b0, 1'b0);
            end
            begin
                at(27);
                chk("seamless busy", 64'(busy), 64'd1);
            end
        join
        at(40);

        // FIFO full: fifth command refused; idle bus fails each preamble
        do_reset();
        for (int i = 0; i < 5; i++) send(24'h500000 + 24'(i), 8, 1, 31, (i < 4));
        for (int i = 0; i < 4; i++) expect_ev(1, 31 + i, '0, '0, 1'b0);
        at(30);
        chk("full cmd_rdy", 64'(cmd_rdy), 64'd0);
        step();
        chk("after pop cmd_rdy", 64'(cmd_rdy), 64'd1);
        at(36);
        chk("drained busy", 64'(busy), 64'd0);

        // Late command dropped when the bus frees up
        do_reset();
        at(10);
        send(24'h000AAA, 8, 1, 9, 1'b1);
        send(24'h000BBB, 8, 1, 9, 1'b1);
        expect_ev(0, 27, 24'h000AAA, 64'h1122334455667788, 1'b0);
        expect_ev(2, 27, '0, '0, 1'b0);
        burst(18, 1, 8, 64'h1122334455667788, 1'b0, 1'b0);
        at(29);
        chk("late busy", 64'(busy), 64'd0);

        // Stuck strobe
        do_reset();
        at(10);
        send(24'h000CCC, 8, 1, 9, 1'b1);
        expect_ev(0, 27, 24'h000CCC, 64'hCAFEF00DDEADBEEF, 1'b1);
        burst(18, 1, 8, 64'hCAFEF00DDEADBEEF, 1'b0, 1'b1);
        at(29);

        // Reset in the middle of a burst
        do_reset();
        at(10);
        send(24'h000DDD, 8, 1, 9, 1'b1);
        fork
            burst(18, 1, 8, 64'h8877665544332211, 1'b0, 1'b0);
            begin
                at(22);
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("midreset wr_valid", 64'(wr_valid), 64'd0);
                chk("midreset busy", 64'(busy), 64'd0);
                chk("midreset cmd_rdy", 64'(cmd_rdy), 64'd1);
            end
        join
        repeat (12) step();

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
